// File: rtl/pipe_credit_sink.sv
// Receive buffer at the tail of a fixed-latency, no-stall pipe. A credit counter
// limits launches so that words in flight plus words held never exceed DEPTH.
module pipe_credit_sink #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_issue,
   output logic             up_can_issue,
   input  logic             pipe_valid,
   input  logic [WIDTH-1:0] pipe_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] credits,
   output logic [CNT_W-1:0] level,
   output logic             overflow_err
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("pipe_credit_sink: DEPTH must be a power of two and >= 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0] level_q, credits_q;
   logic             ovf_q;
   logic             full, pop, push, drop;

   // Full/empty come from the occupancy count; equal pointers are ambiguous.
   assign full      = (level_q == FULL);
   assign out_valid = (level_q != '0);
   assign pop       = out_valid & out_ready;
   assign push      = pipe_valid & (~full | pop);
   assign drop      = pipe_valid & full & ~pop;

   // Credits are registered, so out_ready never reaches up_can_issue in one cycle.
   assign up_can_issue = (credits_q != '0);
   assign credits      = credits_q;
   assign level        = level_q;
   assign overflow_err = ovf_q;
   assign out_data     = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= pipe_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (drop) ovf_q  <= 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + ONE;
            2'b01:   level_q <= level_q - ONE;
            default: level_q <= level_q;
         endcase
      end
   end

   // Saturate at both ends: a launch without credit or a return beyond DEPTH
   // is a producer bug and must not wrap the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits_q <= FULL;
      end else begin
         case ({up_issue, pop})
            2'b10:   if (credits_q != '0)  credits_q <= credits_q - ONE;
            2'b01:   if (credits_q != FULL) credits_q <= credits_q + ONE;
            default: credits_q <= credits_q;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_credit_sink.sv
// Directed bench: a 6-stage delay line stands in for the pipe feeding the sink.
module tb_pipe_credit_sink;
   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int CNT_W = 4;
   localparam int LAT   = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             up_issue, up_can_issue;
   logic             pipe_valid;
   logic [WIDTH-1:0] pipe_data;
   logic             out_valid, out_ready, overflow_err;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] credits, level;

   logic [WIDTH-1:0] issue_data, ovr_data;
   logic             ovr;
   logic [LAT-1:0]   sh_v;
   logic [WIDTH-1:0] sh_d [LAT];

   int n_cmp = 0;
   int n_err = 0;

   pipe_credit_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .up_issue(up_issue), .up_can_issue(up_can_issue),
      .pipe_valid(pipe_valid), .pipe_data(pipe_data),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .credits(credits), .level(level), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   // Fixed-latency pipe model; cleared by the same reset as the sink.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_v <= '0;
         for (int i = 0; i < LAT; i++) sh_d[i] <= '0;
      end else begin
         sh_v    <= {sh_v[LAT-2:0], up_issue};
         sh_d[0] <= issue_data;
         for (int i = 1; i < LAT; i++) sh_d[i] <= sh_d[i-1];
      end
   end

   assign pipe_valid = ovr | sh_v[LAT-1];
   assign pipe_data  = ovr ? ovr_data : sh_d[LAT-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_credits"}, credits, 8);
      chk({tag, "_level"}, level, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_can_issue"}, up_can_issue, 1);
      chk({tag, "_ovf"}, overflow_err, 0);
      chk({tag, "_out_data"}, out_data, 0);
   endtask

   int k, popped, win_pops, cred_zero;
   logic [7:0] nxt, expd;

   initial begin
      rst = 1'b1; up_issue = 0; out_ready = 0; issue_data = '0;
      ovr = 0; ovr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("in_reset");
      rst = 1'b0;
      repeat (3) tick();
      chk_reset("idle");

      // Fill: 8 launches with downstream stalled
      for (int i = 0; i < 8; i++) begin
         up_issue = 1; issue_data = 8'h11 + 8'(i);
         tick();
      end
      up_issue = 0;
      chk("fill_credits0", credits, 0);
      chk("fill_cannot_issue", up_can_issue, 0);
      repeat (8) tick();
      chk("fill_level", level, 8);
      chk("fill_head", out_data, 8'h11);
      chk("fill_valid", out_valid, 1);
      chk("fill_no_ovf", overflow_err, 0);

      // Drain: one pop and one credit back per cycle
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_data", out_data, 8'h11 + 8'(i));
         tick();
         chk("drain_credits", credits, i + 1);
         chk("drain_level", level, 7 - i);
      end
      chk("drain_empty", out_valid, 0);

      // Streaming at full rate through wrap
      nxt = 0; expd = 0; popped = 0; win_pops = 0; cred_zero = 0;
      for (int c = 0; c < 70; c++) begin
         up_issue   = (c < 60) && up_can_issue;
         issue_data = nxt;
         if (up_issue) nxt++;
         if (out_valid) begin
            chk("stream_data", out_data, expd);
            expd++; popped++;
            if (c >= 10 && c < 60) win_pops++;
         end
         tick();
         if (c < 60 && credits == 0) cred_zero = 1;
      end
      up_issue = 0;
      chk("stream_popped", popped, 60);
      chk("stream_rate", win_pops, 50);
      chk("stream_cred_never0", cred_zero, 0);
      chk("stream_end_level", level, 0);
      chk("stream_end_credits", credits, 8);

      // Simultaneous launch, arrival and pop at level 4 / credits 3
      out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         up_issue = 1; issue_data = 8'hA0 + 8'(i);
         tick();
      end
      up_issue = 0;
      repeat (5) tick();
      chk("same_pre_level", level, 4);
      chk("same_pre_credits", credits, 3);
      chk("same_pre_head", out_data, 8'hA0);
      up_issue = 1; issue_data = 8'hA5; out_ready = 1;
      tick();
      up_issue = 0; out_ready = 0;
      chk("same_level", level, 4);
      chk("same_credits", credits, 3);
      chk("same_head", out_data, 8'hA1);
      out_ready = 1; k = 0;
      for (int c = 0; c < 20; c++) begin
         if (out_valid) begin
            chk("same_order", out_data, 8'hA1 + 8'(k));
            k++;
         end
         tick();
      end
      chk("same_count", k, 5);
      chk("same_end_credits", credits, 8);

      // Overflow and mid-stream reset
      out_ready = 0;
      for (int i = 0; i < 8; i++) begin
         up_issue = 1; issue_data = 8'h31 + 8'(i);
         tick();
      end
      up_issue = 0;
      repeat (8) tick();
      chk("ovf_pre_level", level, 8);
      up_issue = 1; issue_data = 8'h77;
      tick();
      up_issue = 0;
      chk("viol_credits_sat", credits, 0);
      chk("viol_cannot_issue", up_can_issue, 0);
      ovr = 1; ovr_data = 8'hEE;
      tick();
      ovr = 0;
      chk("ovf_flag", overflow_err, 1);
      chk("ovf_level", level, 8);
      chk("ovf_head", out_data, 8'h31);
      tick();
      chk("ovf_sticky", overflow_err, 1);
      out_ready = 1;
      tick();
      chk("ovf_pop_credit", credits, 1);
      chk("ovf_pop_head", out_data, 8'h32);
      #1 rst = 1'b1;
      #1;
      chk_reset("mid_reset");
      tick();
      rst = 1'b0; out_ready = 0;
      repeat (8) tick();
      chk_reset("post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
